// File: rtl/sbp_lookup_stage_gen.sv
// One stage of the scalable-pipelined LPM lookup: owns a node memory, clears it after reset,
// then serves lookup and update beats with a fixed two-cycle latency.
module sbp_lookup_stage_gen #(
    parameter int STAGE_ID      = 1,
    parameter int STAGE_ID_BITS = 6,
    parameter int LOCATION_BITS = 11,
    parameter int IP_BITS       = 32,
    parameter int MEM_DEPTH     = 2048,
    parameter int COUNT_BITS    = 16,
    localparam int LEN_BITS     = $clog2(IP_BITS + 1),
    localparam int RESULT_BITS  = STAGE_ID_BITS + LOCATION_BITS,
    localparam int CHILD_BITS   = STAGE_ID_BITS + LOCATION_BITS + 2
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     ready_o,
    output logic                     state_o,
    input  logic                     valid_i,
    input  logic                     update_i,
    input  logic [IP_BITS-1:0]       ip_addr_i,
    input  logic [LEN_BITS-1:0]      bit_pos_i,
    input  logic [STAGE_ID_BITS-1:0] stage_id_i,
    input  logic [LOCATION_BITS-1:0] location_i,
    input  logic [CHILD_BITS-1:0]    child_i,
    input  logic [RESULT_BITS-1:0]   result_i,
    input  logic [LEN_BITS-1:0]      match_len_i,
    output logic                     valid_o,
    output logic                     update_o,
    output logic [IP_BITS-1:0]       ip_addr_o,
    output logic [LEN_BITS-1:0]      bit_pos_o,
    output logic [STAGE_ID_BITS-1:0] stage_id_o,
    output logic [LOCATION_BITS-1:0] location_o,
    output logic [RESULT_BITS-1:0]   result_o,
    output logic [LEN_BITS-1:0]      match_len_o,
    output logic [COUNT_BITS-1:0]    hit_count_o
);

    // Handshake: a beat is taken on every clock edge where valid_i && ready_o; there is
    // no downstream backpressure, so valid_o is simply the accepted valid delayed by two.

    localparam int WORD_BITS = IP_BITS + LEN_BITS + CHILD_BITS;
    localparam int ADDR_BITS = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_BITS-1:0]     LAST_ADDR = ADDR_BITS'(MEM_DEPTH - 1);
    localparam logic [STAGE_ID_BITS-1:0] MY_ID     = STAGE_ID_BITS'(STAGE_ID);
    localparam logic [LEN_BITS-1:0]      LAST_BIT  = LEN_BITS'(IP_BITS - 1);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                 state;
    logic [ADDR_BITS-1:0]   clr_ptr;

    logic [WORD_BITS-1:0]   mem [MEM_DEPTH];
    logic [WORD_BITS-1:0]   rd_q;
    logic                   mem_we;
    logic [ADDR_BITS-1:0]   mem_waddr;
    logic [WORD_BITS-1:0]   mem_wdata;

    logic                   beat_valid;
    logic                   sel;
    logic                   in_range;
    logic [ADDR_BITS-1:0]   in_addr;

    logic                     s1_valid;
    logic                     s1_update;
    logic                     s1_lookup;
    logic                     s1_oob;
    logic [IP_BITS-1:0]       s1_ip;
    logic [LEN_BITS-1:0]      s1_bit_pos;
    logic [STAGE_ID_BITS-1:0] s1_stage_id;
    logic [LOCATION_BITS-1:0] s1_loc;
    logic [RESULT_BITS-1:0]   s1_result;
    logic [LEN_BITS-1:0]      s1_match_len;

    logic [WORD_BITS-1:0]     word;
    logic [IP_BITS-1:0]       w_prefix;
    logic [LEN_BITS-1:0]      w_len;
    logic [STAGE_ID_BITS-1:0] w_child_stage;
    logic [LOCATION_BITS-1:0] w_child_loc;
    logic                     w_has_left;
    logic                     w_has_right;
    logic [IP_BITS-1:0]       mask;
    logic [IP_BITS-1:0]       shifted_ip;
    logic                     go_right;
    logic                     take_child;
    logic                     prefix_hit;
    logic                     do_hit;

    logic [STAGE_ID_BITS-1:0] n_stage_id;
    logic [LOCATION_BITS-1:0] n_loc;
    logic [LEN_BITS-1:0]      n_bit_pos;
    logic [RESULT_BITS-1:0]   n_result;
    logic [LEN_BITS-1:0]      n_match_len;

    assign state_o = (state == S_RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_INIT;
            clr_ptr <= '0;
            ready_o <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    if (clr_ptr == LAST_ADDR) begin
                        state   <= S_RUN;
                        ready_o <= 1'b1;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                S_RUN:   ready_o <= 1'b1;
                default: state   <= S_INIT;
            endcase
        end
    end

    assign beat_valid = valid_i && ready_o;
    assign sel        = beat_valid && (stage_id_i == MY_ID);
    assign in_range   = ({1'b0, location_i} < (LOCATION_BITS + 1)'(MEM_DEPTH));
    assign in_addr    = location_i[ADDR_BITS-1:0];

    // The clear sweep owns the single write port until the stage is running.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = in_addr;
        mem_wdata = {ip_addr_i, bit_pos_i, child_i};
        if (state == S_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr;
            mem_wdata = '0;
        end else if (sel && update_i && in_range) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (sel && !update_i && in_range) begin
            rd_q <= mem[in_addr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid     <= 1'b0;
            s1_update    <= 1'b0;
            s1_lookup    <= 1'b0;
            s1_oob       <= 1'b0;
            s1_ip        <= '0;
            s1_bit_pos   <= '0;
            s1_stage_id  <= '0;
            s1_loc       <= '0;
            s1_result    <= '0;
            s1_match_len <= '0;
        end else begin
            s1_valid     <= beat_valid;
            s1_update    <= update_i;
            s1_lookup    <= sel && !update_i;
            s1_oob       <= !in_range;
            s1_ip        <= ip_addr_i;
            s1_bit_pos   <= bit_pos_i;
            s1_stage_id  <= stage_id_i;
            s1_loc       <= location_i;
            s1_result    <= result_i;
            s1_match_len <= match_len_i;
        end
    end

    // Out-of-range nodes behave like an empty (all-zero) entry.
    assign word          = s1_oob ? '0 : rd_q;
    assign w_prefix      = word[WORD_BITS-1 -: IP_BITS];
    assign w_len         = word[CHILD_BITS +: LEN_BITS];
    assign w_child_stage = word[LOCATION_BITS+2 +: STAGE_ID_BITS];
    assign w_child_loc   = word[2 +: LOCATION_BITS];
    assign w_has_left    = word[1];
    assign w_has_right   = word[0];

    assign mask       = ~({IP_BITS{1'b1}} >> w_len);
    assign prefix_hit = (((s1_ip ^ w_prefix) & mask) == '0) && (w_len >= s1_match_len);
    assign shifted_ip = s1_ip << s1_bit_pos;
    assign go_right   = shifted_ip[IP_BITS-1];
    assign take_child = (go_right ? w_has_right : w_has_left) && (s1_bit_pos < LAST_BIT);
    assign do_hit     = s1_valid && s1_lookup && prefix_hit;

    always_comb begin
        n_stage_id  = s1_stage_id;
        n_loc       = s1_loc;
        n_bit_pos   = s1_bit_pos;
        n_result    = s1_result;
        n_match_len = s1_match_len;
        if (s1_valid && s1_lookup) begin
            if (prefix_hit) begin
                n_result    = {MY_ID, s1_loc};
                n_match_len = w_len;
            end
            if (take_child) begin
                n_stage_id = w_child_stage;
                n_loc      = w_child_loc + LOCATION_BITS'(go_right);
                n_bit_pos  = s1_bit_pos + 1'b1;
            end else begin
                n_stage_id = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o     <= 1'b0;
            update_o    <= 1'b0;
            ip_addr_o   <= '0;
            bit_pos_o   <= '0;
            stage_id_o  <= '0;
            location_o  <= '0;
            result_o    <= '0;
            match_len_o <= '0;
            hit_count_o <= '0;
        end else begin
            valid_o     <= s1_valid;
            update_o    <= s1_update;
            ip_addr_o   <= s1_ip;
            bit_pos_o   <= n_bit_pos;
            stage_id_o  <= n_stage_id;
            location_o  <= n_loc;
            result_o    <= n_result;
            match_len_o <= n_match_len;
            if (do_hit && (hit_count_o != '1)) begin
                hit_count_o <= hit_count_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sbp_lookup_stage_gen.sv
// Directed bench for sbp_lookup_stage_gen: small memory (16 nodes) and a 3-bit hit counter
// so the clear sweep and counter saturation are reachable in a short run.
module tb_sbp_lookup_stage_gen;
  localparam int OB = 80;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ready_o, state_o;
  logic        valid_i, update_i;
  logic [31:0] ip_addr_i;
  logic [5:0]  bit_pos_i, stage_id_i, match_len_i;
  logic [10:0] location_i;
  logic [18:0] child_i;
  logic [16:0] result_i;
  logic        valid_o, update_o;
  logic [31:0] ip_addr_o;
  logic [5:0]  bit_pos_o, stage_id_o, match_len_o;
  logic [10:0] location_o;
  logic [16:0] result_o;
  logic [2:0]  hit_count_o;
  logic [OB-1:0] out_bus;

  int n_vec = 0;
  int n_err = 0;
  logic [OB-1:0] exp_q[$];

  always #5 clk = ~clk;

  sbp_lookup_stage_gen #(
    .STAGE_ID(1), .STAGE_ID_BITS(6), .LOCATION_BITS(11), .IP_BITS(32),
    .MEM_DEPTH(16), .COUNT_BITS(3)
  ) dut (
    .clk(clk), .rst(rst), .ready_o(ready_o), .state_o(state_o),
    .valid_i(valid_i), .update_i(update_i), .ip_addr_i(ip_addr_i), .bit_pos_i(bit_pos_i),
    .stage_id_i(stage_id_i), .location_i(location_i), .child_i(child_i),
    .result_i(result_i), .match_len_i(match_len_i),
    .valid_o(valid_o), .update_o(update_o), .ip_addr_o(ip_addr_o), .bit_pos_o(bit_pos_o),
    .stage_id_o(stage_id_o), .location_o(location_o), .result_o(result_o),
    .match_len_o(match_len_o), .hit_count_o(hit_count_o)
  );

  assign out_bus = {valid_o, update_o, ip_addr_o, bit_pos_o, stage_id_o, location_o, result_o, match_len_o};

  function automatic logic [OB-1:0] mk(input logic v, input logic u, input logic [31:0] ip,
                                       input logic [5:0] bp, input logic [5:0] sid,
                                       input logic [10:0] loc, input logic [16:0] res,
                                       input logic [5:0] ml);
    return {v, u, ip, bp, sid, loc, res, ml};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic v, input logic u, input logic [31:0] ip, input logic [5:0] bp,
                      input logic [5:0] sid, input logic [10:0] loc, input logic [18:0] child,
                      input logic [16:0] res, input logic [5:0] ml);
    valid_i = v; update_i = u; ip_addr_i = ip; bit_pos_i = bp; stage_id_i = sid;
    location_i = loc; child_i = child; result_i = res; match_len_i = ml;
  endtask

  task automatic idle();
    send(1'b0, 1'b0, '0, '0, '0, '0, '0, '0, '0);
  endtask

  // Called at a negedge; returns at the negedge where the beat's outputs are visible.
  task automatic lookup1(input logic [31:0] ip, input logic [5:0] bp, input logic [10:0] loc,
                         input logic [16:0] res, input logic [5:0] ml);
    send(1'b1, 1'b0, ip, bp, 6'd1, loc, '0, res, ml);
    @(negedge clk); idle();
    @(negedge clk);
  endtask

  task automatic write1(input logic [10:0] loc, input logic [31:0] prefix, input logic [5:0] len,
                        input logic [18:0] child);
    send(1'b1, 1'b1, prefix, len, 6'd1, loc, child, '0, '0);
    @(negedge clk); idle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int cycles;
    logic [OB-1:0] e;
    idle();
    repeat (3) @(negedge clk);
    n_vec++; if (out_bus !== '0) begin n_err++; $display("FAIL reset_outputs got %h exp 0", out_bus); end
    n_vec++; if ({ready_o, state_o, hit_count_o} !== 5'b0) begin
      n_err++; $display("FAIL reset_ready got %b exp 00000", {ready_o, state_o, hit_count_o}); end
    // A lookup held during the clear sweep must not produce an output beat.
    send(1'b1, 1'b0, 32'h1234_5678, 6'd0, 6'd1, 11'd2, '0, '0, 6'd0);
    rst = 1'b1;
    cycles = 0;
    while (ready_o !== 1'b1 && cycles < 100) begin
      @(posedge clk); #1; cycles++;
      n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL init_valid got %b exp 0 cycle %0d", valid_o, cycles); end
    end
    n_vec++; if (cycles != 16) begin n_err++; $display("FAIL init_cycles got %0d exp 16", cycles); end
    n_vec++; if (state_o !== 1'b1) begin n_err++; $display("FAIL run_state got %b exp 1", state_o); end
    @(negedge clk); idle();
    repeat (2) @(negedge clk);
    n_vec++; if (valid_o !== 1'b0 || hit_count_o !== 3'd0) begin
      n_err++; $display("FAIL init_drain got v=%b hits=%0d exp v=0 hits=0", valid_o, hit_count_o); end
    lookup1(32'h0102_0304, 6'd3, 11'd3, 17'h0ABCD, 6'd1);
    e = mk(1'b1, 1'b0, 32'h0102_0304, 6'd3, 6'd0, 11'd3, 17'h0ABCD, 6'd1);
    n_vec++; if (out_bus !== e) begin n_err++; $display("FAIL empty_lookup got %h exp %h", out_bus, e); end
  endtask

  task automatic test_lookup();
    logic [OB-1:0] e;
    write1(11'd5, 32'h0A00_0000, 6'd8, {6'd2, 11'd40, 1'b1, 1'b1});
    @(negedge clk);
    e = mk(1'b1, 1'b1, 32'h0A00_0000, 6'd8, 6'd1, 11'd5, 17'd0, 6'd0);
    n_vec++; if (out_bus !== e) begin n_err++; $display("FAIL update_pass got %h exp %h", out_bus, e); end
    lookup1(32'h0A01_0203, 6'd8, 11'd5, 17'd0, 6'd0);
    e = mk(1'b1, 1'b0, 32'h0A01_0203, 6'd9, 6'd2, 11'd40, {6'd1, 11'd5}, 6'd8);
    n_vec++; if (out_bus !== e) begin n_err++; $display("FAIL lookup_left got %h exp %h", out_bus, e); end
    n_vec++; if (hit_count_o !== 3'd1) begin n_err++; $display("FAIL hits_1 got %0d exp 1", hit_count_o); end
  endtask

  task automatic test_child();
    logic [OB-1:0] e;
    lookup1(32'h0A80_0000, 6'd8, 11'd5, 17'd0, 6'd0);
    e = mk(1'b1, 1'b0, 32'h0A80_0000, 6'd9, 6'd2, 11'd41, {6'd1, 11'd5}, 6'd8);
    n_vec++; if (out_bus !== e) begin n_err++; $display("FAIL lookup_right got %h exp %h", out_bus, e); end
    lookup1(32'h0B00_0000, 6'd8, 11'd5, 17'h00123, 6'd3);
    e = mk(1'b1, 1'b0, 32'h0B00_0000, 6'd9, 6'd2, 11'd40, 17'h00123, 6'd3);
    n_vec++; if (out_bus !== e) begin n_err++; $display("FAIL lookup_nomatch got %h exp %h", out_bus, e); end
    n_vec++; if (hit_count_o !== 3'd2) begin n_err++; $display("FAIL hits_2 got %0d exp 2", hit_count_o); end
  endtask

  task automatic test_len();
    logic [OB-1:0] e;
    write1(11'd6, 32'hA000_0000, 6'd4, {6'd3, 11'd100, 1'b1, 1'b0});
    lookup1(32'hA800_0000, 6'd4, 11'd6, 17'h00ABC, 6'd8);
    e = mk(1'b1, 1'b0, 32'hA800_0000, 6'd4, 6'd0, 11'd6, 17'h00ABC, 6'd8);
    n_vec++; if (out_bus !== e) begin n_err++; $display("FAIL shorter_len got %h exp %h", out_bus, e); end
    write1(11'd7, 32'h0000_0000, 6'd0, {6'd4, 11'd10, 1'b1, 1'b1});
    lookup1(32'h0000_0000, 6'd31, 11'd7, 17'd0, 6'd0);
    e = mk(1'b1, 1'b0, 32'h0000_0000, 6'd31, 6'd0, 11'd7, {6'd1, 11'd7}, 6'd0);
    n_vec++; if (out_bus !== e) begin n_err++; $display("FAIL last_bit got %h exp %h", out_bus, e); end
    lookup1(32'h0000_0001, 6'd30, 11'd7, 17'd0, 6'd0);
    e = mk(1'b1, 1'b0, 32'h0000_0001, 6'd31, 6'd4, 11'd10, {6'd1, 11'd7}, 6'd0);
    n_vec++; if (out_bus !== e) begin n_err++; $display("FAIL bit30_child got %h exp %h", out_bus, e); end
    n_vec++; if (hit_count_o !== 3'd4) begin n_err++; $display("FAIL hits_4 got %0d exp 4", hit_count_o); end
  endtask

  task automatic test_back_to_back();
    logic [OB-1:0] e;
    send(1'b1, 1'b1, 32'hC0A8_0000, 6'd16, 6'd1, 11'd8, {6'd5, 11'd20, 1'b0, 1'b1}, '0, '0);
    @(negedge clk);
    send(1'b1, 1'b0, 32'hC0A8_8000, 6'd16, 6'd1, 11'd8, '0, '0, 6'd8);
    @(negedge clk); idle();
    e = mk(1'b1, 1'b1, 32'hC0A8_0000, 6'd16, 6'd1, 11'd8, 17'd0, 6'd0);
    n_vec++; if (out_bus !== e) begin n_err++; $display("FAIL b2b_write got %h exp %h", out_bus, e); end
    @(negedge clk);
    e = mk(1'b1, 1'b0, 32'hC0A8_8000, 6'd17, 6'd5, 11'd21, {6'd1, 11'd8}, 6'd16);
    n_vec++; if (out_bus !== e) begin n_err++; $display("FAIL b2b_lookup got %h exp %h", out_bus, e); end
    n_vec++; if (hit_count_o !== 3'd5) begin n_err++; $display("FAIL hits_5 got %0d exp 5", hit_count_o); end
    // Update beyond the memory must not alias onto node 4.
    write1(11'd20, 32'h8000_0000, 6'd1, {6'd1, 11'd1, 1'b1, 1'b1});
    lookup1(32'h8000_0000, 6'd0, 11'd4, 17'd0, 6'd1);
    e = mk(1'b1, 1'b0, 32'h8000_0000, 6'd0, 6'd0, 11'd4, 17'd0, 6'd1);
    n_vec++; if (out_bus !== e) begin n_err++; $display("FAIL oob_alias got %h exp %h", out_bus, e); end
    lookup1(32'h8000_0000, 6'd0, 11'd20, 17'd0, 6'd1);
    e = mk(1'b1, 1'b0, 32'h8000_0000, 6'd0, 6'd0, 11'd20, 17'd0, 6'd1);
    n_vec++; if (out_bus !== e) begin n_err++; $display("FAIL oob_read got %h exp %h", out_bus, e); end
  endtask

  task automatic test_passthrough();
    logic [OB-1:0] e;
    logic v, u;
    logic [31:0] ip;
    logic [10:0] loc;
    logic [16:0] res;
    for (int i = 0; i < 12; i++) begin
      if (i >= 2) begin
        e = exp_q.pop_front();
        n_vec++; if (out_bus !== e) begin n_err++; $display("FAIL pass_beat%0d got %h exp %h", i - 2, out_bus, e); end
      end
      if (i < 10) begin
        v = (i % 4 != 2); u = i[0]; ip = 32'h8000_0000 | i; loc = 11'(i + 2); res = 17'(i * 7 + 1);
        send(v, u, ip, 6'(i), 6'd3, loc, 19'(i * 3), res, 6'(i));
        exp_q.push_back(mk(v, u, ip, 6'(i), 6'd3, loc, res, 6'(i)));
      end else begin
        idle();
      end
      @(negedge clk);
    end
    // An invalid beat addressed to this stage must not write either.
    send(1'b0, 1'b1, 32'h8000_0000, 6'd1, 6'd1, 11'd9, 19'h7FFFF, '0, '0);
    @(negedge clk); idle();
    lookup1(32'h8000_0000, 6'd0, 11'd9, 17'd0, 6'd1);
    e = mk(1'b1, 1'b0, 32'h8000_0000, 6'd0, 6'd0, 11'd9, 17'd0, 6'd1);
    n_vec++; if (out_bus !== e) begin n_err++; $display("FAIL invalid_nowrite got %h exp %h", out_bus, e); end
    lookup1(32'h8000_0000, 6'd0, 11'd3, 17'd0, 6'd1);
    e = mk(1'b1, 1'b0, 32'h8000_0000, 6'd0, 6'd0, 11'd3, 17'd0, 6'd1);
    n_vec++; if (out_bus !== e) begin n_err++; $display("FAIL other_stage_nowrite got %h exp %h", out_bus, e); end
    n_vec++; if (hit_count_o !== 3'd5) begin n_err++; $display("FAIL hits_still5 got %0d exp 5", hit_count_o); end
  endtask

  task automatic test_reset_in_flight();
    int cycles;
    logic [OB-1:0] e;
    send(1'b1, 1'b0, 32'h0, 6'd0, 6'd1, 11'd0, '0, '0, 6'd0);
    @(negedge clk);
    send(1'b1, 1'b0, 32'h0, 6'd0, 6'd1, 11'd1, '0, '0, 6'd0);
    @(posedge clk); #1;
    n_vec++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL inflight_valid got %b exp 1", valid_o); end
    rst = 1'b0; #1;
    n_vec++; if ({valid_o, ready_o, state_o, hit_count_o} !== 6'b0) begin
      n_err++; $display("FAIL abort got %b exp 000000", {valid_o, ready_o, state_o, hit_count_o}); end
    idle();
    repeat (2) @(negedge clk);
    n_vec++; if (out_bus !== '0) begin n_err++; $display("FAIL abort_outputs got %h exp 0", out_bus); end
    rst = 1'b1;
    cycles = 0;
    while (ready_o !== 1'b1 && cycles < 100) begin
      @(posedge clk); #1; cycles++;
    end
    n_vec++; if (cycles != 16) begin n_err++; $display("FAIL reinit_cycles got %0d exp 16", cycles); end
    @(negedge clk);
    lookup1(32'h0A01_0203, 6'd8, 11'd5, 17'd0, 6'd1);
    e = mk(1'b1, 1'b0, 32'h0A01_0203, 6'd8, 6'd0, 11'd5, 17'd0, 6'd1);
    n_vec++; if (out_bus !== e) begin n_err++; $display("FAIL mem_cleared got %h exp %h", out_bus, e); end
  endtask

  task automatic test_saturate();
    logic [OB-1:0] e;
    // Empty nodes with match_len_i=0 hit every time; nine hits must stop at 7.
    for (int i = 0; i < 9; i++) begin
      send(1'b1, 1'b0, 32'h0, 6'd0, 6'd1, 11'(i), '0, '0, 6'd0);
      @(negedge clk);
    end
    idle();
    repeat (2) @(negedge clk);
    n_vec++; if (hit_count_o !== 3'd7) begin n_err++; $display("FAIL saturate got %0d exp 7", hit_count_o); end
    e = mk(1'b0, 1'b0, 32'h0, 6'd0, 6'd0, 11'd0, 17'd0, 6'd0);
    n_vec++; if (out_bus !== e) begin n_err++; $display("FAIL sat_idle got %h exp %h", out_bus, e); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lookup();
    test_child();
    test_len();
    test_back_to_back();
    test_passthrough();
    test_reset_in_flight();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
